// File: rtl/cnn_pkg.sv
// Shared grid constants, monitor state encoding and the cell packing helper.
package cnn_pkg;

   localparam int WIDTH     = 9;
   localparam int N_CELLS   = 16;
   localparam int SWEEP_LEN = 16;
   localparam int PHASE_W   = $clog2(SWEEP_LEN);
   localparam int STABLE_W  = 4;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   function automatic int cell_slice(input int k);
      return k * WIDTH;
   endfunction

endpackage

// File: rtl/cnn_cell_cmp.sv
// Per-cell unchanged test against the previous sweep plus sign binarization; purely combinational.
// CNN_SETTLE_TOL_EN widens "unchanged" to |y - prev| <= TOL, otherwise exact equality.
module cnn_cell_cmp
   import cnn_pkg::*;
`ifdef CNN_SETTLE_TOL_EN
#(
   parameter int TOL = 1
)
`endif
(
   input  logic [WIDTH-1:0] y_i,
   input  logic [WIDTH-1:0] prev_i,
   output logic             same_o,
   output logic             bin_o
);

`ifdef CNN_SETTLE_TOL_EN
   // One extra bit keeps the signed difference from overflowing.
   logic signed [WIDTH:0] diff;
   logic        [WIDTH:0] mag;

   always_comb begin
      diff   = $signed({y_i[WIDTH-1], y_i}) - $signed({prev_i[WIDTH-1], prev_i});
      mag    = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      same_o = (mag <= (WIDTH+1)'(TOL));
   end
`else
   assign same_o = (y_i == prev_i);
`endif

   assign bin_o = ~y_i[WIDTH-1] & (|y_i);

endmodule

// File: rtl/cnn_settle_monitor.sv
// Samples the 4x4 CNN grid once per sweep; result registers on the deciding sample, out_valid one cycle later.
// Result is held under out_ready backpressure; CNN_SETTLE_TOL_EN enables the tolerance compare.
module cnn_settle_monitor
   import cnn_pkg::*;
#(
   parameter int STABLE_SWEEPS = 2,
   parameter int MAX_ITER      = 64,
   parameter int ITER_W        = 7
`ifdef CNN_SETTLE_TOL_EN
   ,
   parameter int TOL           = 1
`endif
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [N_CELLS*WIDTH-1:0] y_flat,
   output logic                     busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_CELLS-1:0]       bin_out,
   output logic [ITER_W-1:0]        iter_count,
   output logic                     converged,
   output logic                     timeout
);

   state_t                   state_q, state_d;
   logic [PHASE_W-1:0]       phase_q, phase_d;
   logic [ITER_W-1:0]        iter_q, iter_d;
   logic [STABLE_W-1:0]      stable_q, stable_d;
   logic [N_CELLS*WIDTH-1:0] prev_q, prev_d;
   logic                     first_q, first_d;
   logic                     conv_q, conv_d;
   logic                     tmo_q, tmo_d;
   logic                     valid_q, valid_d;
   logic [N_CELLS-1:0]       bin_q, bin_d;

   logic [N_CELLS-1:0]       same_vec;
   logic [N_CELLS-1:0]       bin_vec;
   logic                     sample;

   for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
      cnn_cell_cmp
`ifdef CNN_SETTLE_TOL_EN
         #(.TOL(TOL))
`endif
         u_cmp (
            .y_i    (y_flat[cell_slice(k) +: WIDTH]),
            .prev_i (prev_q[cell_slice(k) +: WIDTH]),
            .same_o (same_vec[k]),
            .bin_o  (bin_vec[k])
         );
   end

   assign sample = (phase_q == PHASE_W'(SWEEP_LEN - 1));

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      iter_d   = iter_q;
      stable_d = stable_q;
      prev_d   = prev_q;
      first_d  = first_q;
      conv_d   = conv_q;
      tmo_d    = tmo_q;
      valid_d  = valid_q;
      bin_d    = bin_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               phase_d  = '0;
               iter_d   = '0;
               stable_d = '0;
               conv_d   = 1'b0;
               tmo_d    = 1'b0;
               first_d  = 1'b1;
            end
         end
         RUN: begin
            phase_d = sample ? '0 : phase_q + 1'b1;
            if (sample) begin
               iter_d  = iter_q + 1'b1;
               prev_d  = y_flat;
               first_d = 1'b0;
               // The very first snapshot has nothing valid to compare against.
               if ((&same_vec) && !first_q) begin
                  stable_d = (&stable_q) ? stable_q : stable_q + 1'b1;
               end else begin
                  stable_d = '0;
               end
               if (stable_d == STABLE_W'(STABLE_SWEEPS)) begin
                  state_d = HOLD;
                  conv_d  = 1'b1;
                  bin_d   = bin_vec;
               end else if (iter_d == ITER_W'(MAX_ITER)) begin
                  state_d = HOLD;
                  tmo_d   = 1'b1;
                  bin_d   = bin_vec;
               end
            end
         end
         HOLD: begin
            if (!valid_q) begin
               valid_d = 1'b1;
            end else if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         iter_q   <= '0;
         stable_q <= '0;
         prev_q   <= '0;
         first_q  <= 1'b1;
         conv_q   <= 1'b0;
         tmo_q    <= 1'b0;
         valid_q  <= 1'b0;
         bin_q    <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         iter_q   <= iter_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
         first_q  <= first_d;
         conv_q   <= conv_d;
         tmo_q    <= tmo_d;
         valid_q  <= valid_d;
         bin_q    <= bin_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign out_valid  = valid_q;
   assign bin_out    = bin_q;
   assign iter_count = iter_q;
   assign converged  = conv_q;
   assign timeout    = tmo_q;

endmodule

// File: tb/tb_cnn_settle_monitor.sv
// Directed and randomized sweeps checked against a sweep-level reference model of the settle monitor.
module tb_cnn_settle_monitor;
   import cnn_pkg::*;

   localparam int STABLE = 2;
   localparam int MAXI   = 64;
`ifdef CNN_SETTLE_TOL_EN
   localparam int TOLM = 1;
`else
   localparam int TOLM = 0;
`endif

   typedef logic [N_CELLS*WIDTH-1:0] snap_t;

   logic               clk = 1'b0;
   logic               rst, start, out_ready;
   logic               busy, out_valid, converged, timeout;
   snap_t              y_flat;
   logic [N_CELLS-1:0] bin_out;
   logic [6:0]         iter_count;

   int    n_chk  = 0;
   int    n_fail = 0;
   snap_t snaps[$];

   always #5 clk = ~clk;

   cnn_settle_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .y_flat     (y_flat),
      .busy       (busy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .bin_out    (bin_out),
      .iter_count (iter_count),
      .converged  (converged),
      .timeout    (timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int cell_of(input snap_t s, input int k);
      logic signed [WIDTH-1:0] c;
      c = s[k*WIDTH +: WIDTH];
      return int'(c);
   endfunction

   function automatic snap_t with_cell(input snap_t s, input int k, input int v);
      snap_t r;
      r = s;
      r[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
      return r;
   endfunction

   function automatic snap_t all_cells(input int v);
      snap_t r;
      r = '0;
      for (int k = 0; k < N_CELLS; k++) r = with_cell(r, k, v);
      return r;
   endfunction

   // Sweep-level model: cells unchanged within TOLM, settle after STABLE unchanged transitions.
   function automatic bit same_snap(input snap_t a, input snap_t b);
      for (int k = 0; k < N_CELLS; k++) begin
         int d;
         d = cell_of(a, k) - cell_of(b, k);
         if (d < 0) d = -d;
         if (d > TOLM) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [15:0] binz(input snap_t s);
      logic [15:0] b;
      for (int k = 0; k < N_CELLS; k++) b[k] = (cell_of(s, k) > 0);
      return b;
   endfunction

   task automatic model(output int n, output bit conv, output logic [15:0] bexp);
      int run;
      run  = 0;
      n    = MAXI;
      conv = 1'b0;
      for (int i = 0; i < MAXI; i++) begin
         if (i > 0 && same_snap(snaps[i], snaps[i-1])) run++;
         else run = 0;
         if (run >= STABLE) begin
            n    = i + 1;
            conv = 1'b1;
            break;
         end
      end
      bexp = binz(snaps[n-1]);
   endtask

   task automatic run_case(input string tag, input int hold);
      int          n;
      bit          conv;
      logic [15:0] bexp;
      model(n, conv, bexp);
      y_flat = snaps[0];
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int j = 0; j < n; j++) begin
         y_flat = snaps[j];
         repeat (SWEEP_LEN - 1) tick();
         if (j == n - 1) begin
            chk({tag, "/pre_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "/pre_busy"}, 32'(busy), 32'd1);
         end
         tick();
      end
      chk({tag, "/converged"}, 32'(converged), 32'(conv));
      chk({tag, "/timeout"}, 32'(timeout), 32'(!conv));
      chk({tag, "/iter"}, 32'(iter_count), 32'(n));
      chk({tag, "/bin"}, 32'(bin_out), 32'(bexp));
      chk({tag, "/valid_lat"}, 32'(out_valid), 32'd0);
      out_ready = (hold == 0);
      tick();
      chk({tag, "/valid"}, 32'(out_valid), 32'd1);
      if (hold > 0) begin
         y_flat = ~y_flat;
         repeat (hold) tick();
         chk({tag, "/bp_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "/bp_bin"}, 32'(bin_out), 32'(bexp));
         chk({tag, "/bp_iter"}, 32'(iter_count), 32'(n));
         chk({tag, "/bp_conv"}, 32'(converged), 32'(conv));
         out_ready = 1'b1;
      end
      tick();
      chk({tag, "/post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/post_busy"}, 32'(busy), 32'd0);
      chk({tag, "/post_bin"}, 32'(bin_out), 32'(bexp));
      out_ready = 1'b0;
   endtask

   initial begin
      snap_t       base, s;
      logic [159:0] r;
      int          pct;

      rst = 1'b1; start = 1'b0; out_ready = 1'b0; y_flat = '0;
      repeat (2) tick();
      chk("reset/busy", 32'(busy), 32'd0);
      chk("reset/valid", 32'(out_valid), 32'd0);
      chk("reset/bin", 32'(bin_out), 32'd0);
      chk("reset/iter", 32'(iter_count), 32'd0);
      chk("reset/conv", 32'(converged), 32'd0);
      chk("reset/tmo", 32'(timeout), 32'd0);
      rst = 1'b0;
      tick();

      snaps.delete();
      for (int i = 0; i < MAXI; i++) snaps.push_back(all_cells(5));
      run_case("const5", 0);

      base = all_cells(-20);
      base = with_cell(base, 5, 77);
      snaps.delete();
      for (int i = 0; i < MAXI; i++) snaps.push_back(with_cell(base, 0, (i % 2 == 0) ? 3 : -3));
      run_case("osc", 0);

      s = '0;
      for (int k = 0; k < N_CELLS; k++) begin
         case (k % 4)
            0:       s = with_cell(s, k, -7);
            1:       s = with_cell(s, k, 0);
            2:       s = with_cell(s, k, 7);
            default: s = with_cell(s, k, 1);
         endcase
      end
      snaps.delete();
      for (int i = 0; i < MAXI; i++) snaps.push_back(s);
      run_case("signmap", 10);

      base = all_cells(9);
      snaps.delete();
      for (int i = 0; i < MAXI; i++) snaps.push_back(with_cell(base, 1, (i % 2 == 0) ? 4 : 5));
      run_case("tol", 0);

      snaps.delete();
      for (int i = 0; i < MAXI; i++) snaps.push_back(all_cells(5));
      y_flat = snaps[0];
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_run/busy", 32'(busy), 32'd0);
      chk("rst_run/valid", 32'(out_valid), 32'd0);
      chk("rst_run/iter", 32'(iter_count), 32'd0);
      tick();
      run_case("after_rst", 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3 * SWEEP_LEN + 1) tick();
      chk("rst_hold/valid_before", 32'(out_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_hold/valid", 32'(out_valid), 32'd0);
      chk("rst_hold/busy", 32'(busy), 32'd0);
      chk("rst_hold/conv", 32'(converged), 32'd0);
      tick();

      for (int c = 0; c < 8; c++) begin
         r    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         s    = r[N_CELLS*WIDTH-1:0];
         pct  = (c % 4 == 0) ? 95 : int'($urandom_range(5, 60));
         snaps.delete();
         for (int i = 0; i < MAXI; i++) begin
            if (int'($urandom_range(0, 99)) < pct)
               s = with_cell(s, int'($urandom_range(0, N_CELLS - 1)), int'($urandom_range(0, 511)) - 256);
            snaps.push_back(s);
         end
         run_case($sformatf("rand%0d", c), (c % 3 == 1) ? int'($urandom_range(1, 6)) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
